// File: rtl/jtframe_rom_pkg.sv
// Shared definitions for the ROM slot arbiter: FSM encoding and timing constants.
package jtframe_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Quiet cycles (no download, no loop reset) before the arbiter reports ready.
  localparam int READY_DLY = 16;

  // SDRAM word-address width.
  localparam int SDRAM_AW = 22;

endpackage

// File: rtl/jtframe_rom_line.sv
// One 32-bit cache line for a ROM slot: valid bit, tag, data word, hit test
// and 16-bit half select driven by the slot's live word address.
module jtframe_rom_line
  import jtframe_rom_pkg::*;
#(
  parameter int SAW = 18
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clr,
  input  logic           i_we,
  input  logic [SAW-2:0] i_tag,
  input  logic [31:0]    i_data,
  input  logic           i_cs,
  input  logic [SAW-1:0] i_addr,
  output logic           o_ok,
  output logic [15:0]    o_dout
);

  logic           r_valid;
  logic [SAW-2:0] r_tag;
  logic [31:0]    r_data;

  // Line storage: invalidate on clear, otherwise capture a completed fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= 32'h0000_0000;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_data  <= i_data;
    end
  end

  // Hit test against the live address and selection of the addressed half-word.
  always_comb begin
    o_ok   = i_cs & r_valid & (r_tag == i_addr[SAW-1:1]);
    o_dout = i_addr[0] ? r_data[31:16] : r_data[15:0];
  end

endmodule

// File: rtl/jtframe_rom_arb.sv
// ROM slot arbiter: each slot owns a one-line cache; misses are serialised
// onto a single SDRAM read port, round-robin or fixed priority.
module jtframe_rom_arb
  import jtframe_rom_pkg::*;
#(
  parameter int                 SLOTS   = 4,
  parameter int                 SAW     = 18,
  parameter logic [SLOTS*22-1:0] OFFSETS = '0,
  parameter int                 PRIO    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SLOTS-1:0]     slot_cs,
  input  logic [SLOTS*SAW-1:0] slot_addr,
  output logic [SLOTS-1:0]     slot_ok,
  output logic [SLOTS*16-1:0]  slot_dout,
  input  logic                 downloading,
  input  logic                 loop_rst,
  output logic                 sdram_req,
  input  logic                 sdram_ack,
  input  logic                 data_rdy,
  input  logic [31:0]          data_read,
  output logic [21:0]          sdram_addr,
  output logic                 refresh_en,
  output logic                 ready
);

  localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  state_t         r_state;
  state_t         w_next;
  logic [GW-1:0]  r_gnt;
  logic [GW-1:0]  r_last;
  logic [21:0]    r_addr;
  logic [SAW-2:0] r_tag;
  logic [4:0]     r_rdy_cnt;

  logic [SLOTS-1:0] w_pend;
  logic             w_any_pend;
  logic             w_halt;
  logic             w_ready;
  logic             w_take;
  logic             w_fill;
  logic [GW-1:0]    w_start;
  logic [GW-1:0]    w_hi;
  logic [GW-1:0]    w_lo;
  logic             w_hi_found;
  logic [GW-1:0]    w_sel;
  logic [SAW-1:0]   w_sel_addr;
  logic [21:0]      w_addr_nxt;

  // Cache lines, one per slot; a slot is pending while it requests and misses.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_line
      jtframe_rom_line #(.SAW(SAW)) u_line (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_halt),
        .i_we   (w_fill && (r_gnt == GW'(gi))),
        .i_tag  (r_tag),
        .i_data (data_read),
        .i_cs   (slot_cs[gi]),
        .i_addr (slot_addr[gi*SAW +: SAW]),
        .o_ok   (slot_ok[gi]),
        .o_dout (slot_dout[gi*16 +: 16])
      );
      assign w_pend[gi] = slot_cs[gi] & ~slot_ok[gi];
    end
  endgenerate

  // Halt conditions, readiness and the grant handshake qualifier.
  always_comb begin
    w_halt     = downloading | loop_rst;
    w_ready    = (r_rdy_cnt == 5'(READY_DLY)) && !w_halt;
    w_any_pend = |w_pend;
    w_take     = (r_state == ST_IDLE) && w_any_pend && w_ready;
  end

  // Grant search: first pending slot at or after the start index, wrapping to the lowest.
  always_comb begin
    w_start    = (PRIO != 0) ? '0 :
                 ((r_last == GW'(SLOTS-1)) ? '0 : r_last + 1'b1);
    w_hi       = '0;
    w_lo       = '0;
    w_hi_found = 1'b0;
    for (int i = SLOTS-1; i >= 0; i--) begin
      w_lo       = w_pend[i] ? GW'(i) : w_lo;
      w_hi       = (w_pend[i] && (GW'(i) >= w_start)) ? GW'(i) : w_hi;
      w_hi_found = w_hi_found | (w_pend[i] && (GW'(i) >= w_start));
    end
    w_sel      = w_hi_found ? w_hi : w_lo;
    w_sel_addr = slot_addr[w_sel*SAW +: SAW];
    w_addr_nxt = OFFSETS[w_sel*22 +: 22] + 22'({w_sel_addr[SAW-1:1], 1'b0});
  end

  // Ready delay: saturating count of quiet cycles, cleared by download or loop reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_cnt <= 5'd0;
    end else if (w_halt) begin
      r_rdy_cnt <= 5'd0;
    end else if (r_rdy_cnt != 5'(READY_DLY)) begin
      r_rdy_cnt <= r_rdy_cnt + 5'd1;
    end
  end

  // Grant capture: slot index, SDRAM address and tag are frozen for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt  <= '0;
      r_last <= GW'(SLOTS-1);
      r_addr <= 22'd0;
      r_tag  <= '0;
    end else if (w_take) begin
      r_gnt  <= w_sel;
      r_last <= w_sel;
      r_addr <= w_addr_nxt;
      r_tag  <= w_sel_addr[SAW-1:1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and fill strobe; download or loop reset abort to IDLE.
  always_comb begin
    w_next = r_state;
    w_fill = 1'b0;
    if (w_halt) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) w_next = ST_REQ;
          else        w_next = ST_IDLE;
        end
        ST_REQ: begin
          if (sdram_ack) w_next = ST_WAIT;
          else           w_next = ST_REQ;
        end
        ST_WAIT: begin
          if (data_rdy) begin
            w_next = ST_IDLE;
            w_fill = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // SDRAM-side outputs and status.
  always_comb begin
    sdram_req  = (r_state == ST_REQ) && !downloading;
    sdram_addr = r_addr;
    refresh_en = (r_state == ST_IDLE) && !w_any_pend && w_ready;
    ready      = w_ready;
  end

endmodule
